// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ready data bus,
// formats load data and drives the registered MEM/WB outputs.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_ALUResult,
    input  logic [31:0] ex_readData2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regWrite,
    output logic [31:0] wb_data,
    output logic        mem_fault
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StAccess = 1'b1;

    logic [0:0]  state_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [4:0]  rd_q;
    logic        regwrite_q;
    logic        read_q;

    logic [1:0]  ex_off;
    logic        is_mem;
    logic        fault;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_lane;
    logic [31:0] ld_data;

    assign ex_off    = ex_ALUResult[1:0];
    assign is_mem    = ex_memRead | ex_memWrite;
    assign mem_stall = (state_q == StAccess);

    always_comb begin
        fault = 1'b0;
        if (ex_memRead && ex_memWrite)                      fault = 1'b1;
        if (ex_funct3[1:0] == 2'b01 && ex_off[0])           fault = 1'b1;
        if (ex_funct3[1:0] == 2'b10 && ex_off != 2'b00)     fault = 1'b1;
        if (ex_memRead && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111))
            fault = 1'b1;
        if (ex_memWrite && (ex_funct3[2] || ex_funct3 == 3'b011))
            fault = 1'b1;
    end

    // Store data is replicated across lanes; strobes select the addressed bytes.
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        if (ex_memWrite) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    st_wstrb = 4'b0001 << ex_off;
                    st_wdata = {4{ex_readData2[7:0]}};
                end
                2'b01: begin
                    st_wstrb = 4'b0011 << ex_off;
                    st_wdata = {2{ex_readData2[15:0]}};
                end
                default: begin
                    st_wstrb = 4'b1111;
                    st_wdata = ex_readData2;
                end
            endcase
        end
    end

    always_comb begin
        ld_lane = dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'b001:  ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'b100:  ld_data = {24'h0, ld_lane[7:0]};
            3'b101:  ld_data = {16'h0, ld_lane[15:0]};
            default: ld_data = ld_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            rd_q        <= 5'd0;
            regwrite_q  <= 1'b0;
            read_q      <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'h0;
            dmem_wdata  <= 32'h0;
            dmem_wstrb  <= 4'b0000;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_regWrite <= 1'b0;
            wb_data     <= 32'h0;
            mem_fault   <= 1'b0;
        end else if (state_q == StIdle) begin
            mem_fault <= 1'b0;
            wb_valid  <= 1'b0;
            if (ex_valid && !is_mem) begin
                wb_valid    <= 1'b1;
                wb_rd       <= ex_rd;
                wb_regWrite <= ex_regWrite;
                wb_data     <= ex_ALUResult;
            end else if (ex_valid && fault) begin
                wb_regWrite <= 1'b0;
                mem_fault   <= 1'b1;
            end else if (ex_valid) begin
                off_q      <= ex_off;
                funct3_q   <= ex_funct3;
                addr_q     <= ex_ALUResult;
                rd_q       <= ex_rd;
                regwrite_q <= ex_regWrite;
                read_q     <= ex_memRead;
                dmem_req   <= 1'b1;
                dmem_we    <= ex_memWrite;
                dmem_addr  <= {ex_ALUResult[31:2], 2'b00};
                dmem_wdata <= st_wdata;
                dmem_wstrb <= st_wstrb;
                state_q    <= StAccess;
            end
        end else begin
            mem_fault <= 1'b0;
            wb_valid  <= 1'b0;
            if (dmem_ready) begin
                dmem_req    <= 1'b0;
                wb_valid    <= 1'b1;
                wb_rd       <= rd_q;
                wb_regWrite <= regwrite_q;
                wb_data     <= read_q ? ld_data : addr_q;
                state_q     <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected write-backs are queued when an
// instruction is driven and compared when wb_valid appears.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_memRead, ex_memWrite, ex_regWrite;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_ALUResult, ex_readData2;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall, wb_valid, wb_regWrite, mem_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;
    logic [37:0] sb[$];

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_funct3(ex_funct3), .ex_ALUResult(ex_ALUResult), .ex_readData2(ex_readData2),
        .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
        .wb_data(wb_data), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check wb_valid and pop/compare any write-back.
    task automatic cycle(input logic exp_wb);
        logic [37:0] e;
        @(posedge clk);
        #1;
        check("wb_valid", 64'(wb_valid), 64'(exp_wb));
        if (wb_valid) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wb_result", {26'h0, wb_rd, wb_regWrite, wb_data}, {26'h0, e});
            end
        end
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] d,
                         input logic [4:0] rd, input logic rw);
        ex_valid     = 1'b1;
        ex_memRead   = rd_en;
        ex_memWrite  = wr_en;
        ex_funct3    = f3;
        ex_ALUResult = addr;
        ex_readData2 = d;
        ex_rd        = rd;
        ex_regWrite  = rw;
    endtask

    task automatic idle_ex();
        ex_valid    = 1'b0;
        ex_memRead  = 1'b0;
        ex_memWrite = 1'b0;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d,
                         input logic [3:0] strb, input logic [31:0] wdata);
        drive(1'b0, 1'b1, f3, addr, d, 5'd0, 1'b0);
        sb.push_back({5'd0, 1'b0, addr});
        cycle(1'b0);
        idle_ex();
        check("st_req", 64'(dmem_req), 64'd1);
        check("st_we", 64'(dmem_we), 64'd1);
        check("st_addr", 64'(dmem_addr), 64'({addr[31:2], 2'b00}));
        check("st_wstrb", 64'(dmem_wstrb), 64'(strb));
        check("st_wdata", 64'(dmem_wdata), 64'(wdata));
        dmem_ready = 1'b1;
        cycle(1'b1);
        dmem_ready = 1'b0;
        cycle(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_ex();
        ex_funct3 = 3'b000; ex_ALUResult = 32'h0; ex_readData2 = 32'h0;
        ex_rd = 5'd0; ex_regWrite = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        #1;
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_stall", 64'(mem_stall), 64'd0);
        check("rst_wb", {wb_valid, wb_rd, wb_regWrite, wb_data, mem_fault}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Non-memory op passes straight through.
        drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        sb.push_back({5'd5, 1'b1, 32'h1234});
        cycle(1'b1);
        check("alu_stall", 64'(mem_stall), 64'd0);
        idle_ex();
        cycle(1'b0);

        // LB with three wait cycles; a held ALU op follows.
        drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
        sb.push_back({5'd7, 1'b1, 32'hFFFF_FF80});
        cycle(1'b0);
        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd9, 1'b1);
        sb.push_back({5'd9, 1'b1, 32'h55});
        check("lb_addr", 64'(dmem_addr), 64'h100);
        check("lb_wstrb", 64'(dmem_wstrb), 64'h0);
        check("lb_we", 64'(dmem_we), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("lb_req", 64'(dmem_req), 64'd1);
            check("lb_stall", 64'(mem_stall), 64'd1);
            cycle(1'b0);
        end
        check("lb_req_last", 64'(dmem_req), 64'd1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80FF_0011;
        cycle(1'b1);
        dmem_ready = 1'b0;
        check("lb_req_drop", 64'(dmem_req), 64'd0);
        check("lb_stall_drop", 64'(mem_stall), 64'd0);
        cycle(1'b1);
        idle_ex();

        // LHU, ready immediately.
        drive(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd3, 1'b1);
        sb.push_back({5'd3, 1'b1, 32'h0000_BEEF});
        cycle(1'b0);
        idle_ex();
        check("lhu_addr", 64'(dmem_addr), 64'h100);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hBEEF_0000;
        cycle(1'b1);
        dmem_ready = 1'b0;
        cycle(1'b0);

        store(3'b000, 32'h201, 32'hAABB_CCDD, 4'b0010, 32'hDDDD_DDDD);
        store(3'b001, 32'h206, 32'h1234_5678, 4'b1100, 32'h5678_5678);
        store(3'b010, 32'h204, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        // Misaligned LW faults.
        drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd4, 1'b1);
        cycle(1'b0);
        idle_ex();
        check("flt_req", 64'(dmem_req), 64'd0);
        check("flt_pulse", 64'(mem_fault), 64'd1);
        check("flt_regwrite", 64'(wb_regWrite), 64'd0);
        cycle(1'b0);
        check("flt_pulse_end", 64'(mem_fault), 64'd0);

        // Read and write together also faults.
        drive(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd4, 1'b1);
        cycle(1'b0);
        idle_ex();
        check("flt_rw_pulse", 64'(mem_fault), 64'd1);
        check("flt_rw_req", 64'(dmem_req), 64'd0);
        cycle(1'b0);

        // Reset during an access aborts it.
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd6, 1'b1);
        cycle(1'b0);
        idle_ex();
        check("abort_req_pre", 64'(dmem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_req", 64'(dmem_req), 64'd0);
        check("abort_stall", 64'(mem_stall), 64'd0);
        check("abort_wb", {wb_valid, wb_rd, wb_regWrite, wb_data}, 64'd0);
        #3 rst_n = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        cycle(1'b0);
        check("late_ready_req", 64'(dmem_req), 64'd0);
        cycle(1'b0);
        dmem_ready = 1'b0;

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Consumes the EX/MEM-registered ALU result, store data and control; performs loads and stores on a single-port data-memory bus with a req/ready handshake; formats load data; and drives the registered MEM/WB outputs. Stalls upstream while a bus access is outstanding and squashes misaligned or illegal accesses.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_memRead  in  1  load
- ex_memWrite  in  1  store
- ex_funct3  in  3  access size/sign (instruction [14:12])
- ex_ALUResult  in  32  byte address for memory ops; result for all others
- ex_readData2  in  32  store data
- ex_rd  in  5  destination register
- ex_regWrite  in  1  register-write enable
- dmem_req  out  1  bus request; registered
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables; 0000 on reads
- dmem_ready  in  1  access completes in the cycle it is sampled high with dmem_req
- dmem_rdata  in  32  read word; valid when dmem_ready
- mem_stall  out  1  upstream holds EX/MEM contents this cycle
- wb_valid  out  1  MEM/WB holds a valid instruction
- wb_rd  out  5  MEM/WB destination
- wb_regWrite  out  1  MEM/WB write enable
- wb_data  out  32  load data or passed-through ALU result
- mem_fault  out  1  one-cycle pulse, aligned with the squashed slot

## Operation
- States: IDLE, ACCESS.
- Reset (async, rst_n=0): state=IDLE; every output 0, including dmem_req, immediately.
- mem_stall = (state==ACCESS), combinational.
- IDLE, ex_valid=0: wb_valid<=0, mem_fault<=0.
- IDLE, non-memory op (ex_memRead=ex_memWrite=0): wb_valid<=1, wb_rd/wb_regWrite<=ex_*, wb_data<=ex_ALUResult.
- IDLE, memory op, fault check: fault if both memRead and memWrite; half (funct3[1:0]=01) with addr[0]=1; word (funct3[1:0]=10) with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3[2]=1 or funct3=011. On fault: no bus request, wb_valid<=0, wb_regWrite<=0, mem_fault<=1, stay IDLE.
- IDLE, legal memory op: capture addr, byte offset, funct3, rd, regWrite, dmem_* into registers; dmem_req<=1; wb_valid<=0; go ACCESS.
- Store lanes: SB wstrb=0001<<off, wdata={4{d[7:0]}}; SH wstrb=0011<<off, wdata={2{d[15:0]}}; SW wstrb=1111, wdata=d.
- Load format from the selected lane of dmem_rdata: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- ACCESS, dmem_ready=0: hold every dmem_* output stable; wb_valid<=0.
- ACCESS, dmem_ready=1: dmem_req<=0; wb_valid<=1; wb_rd/wb_regWrite from captured values; wb_data<=formatted load (loads) or captured address (stores); go IDLE.
- mem_fault is 0 in every cycle not following a fault.

## Timing
- Non-memory op: 1-cycle latency, ex at edge N -> wb at N+1; no stall.
- Memory op accepted at edge N: dmem_req high from N+1; ready sampled at edge N+k (k>=1) -> wb_valid at N+k; mem_stall high cycles N+1..N+k.
- The held upstream instruction is accepted at the first IDLE edge after completion; a 1-cycle wb bubble minimum between back-to-back memory ops.
- dmem_ready while dmem_req=0 is ignored.
- rst_n low during ACCESS aborts the access; dmem_req drops asynchronously; no wb write follows.

## Test plan
- ex: ALUResult=0x1234, rd=5, regWrite=1, no mem op -> next edge wb_valid=1, wb_rd=5, wb_data=0x1234, mem_stall never 1.
- LB addr=0x103, rdata=0x80FF_0011, ready after 3 wait cycles -> dmem_addr=0x100, wstrb=0000, req held 3+1 cycles, mem_stall high throughout, wb_data=0xFFFF_FF80.
- LHU addr=0x102, rdata=0xBEEF_0000, ready immediately -> wb_data=0x0000_BEEF one edge after req.
- SB addr=0x201, data=0xAABB_CCDD -> dmem_we=1, wstrb=0010, wdata=0xDDDD_DDDD, addr=0x200.
- LW addr=0x102 -> no dmem_req, mem_fault pulse 1 cycle, wb_valid=0, wb_regWrite=0.
- rst_n=0 mid-ACCESS -> dmem_req, mem_stall, all wb_* go 0 without a clock edge; after release state IDLE, a late dmem_ready produces no wb write.
